// File: rtl/ov7670_capture_if.sv
// Camera-side inputs and frame-buffer write outputs of the OV7670 capture stage.
// All signals live in the camera pixel-clock domain; there is no handshake beyond buf_ready.
interface ov7670_capture_if;
    logic        vsync;
    logic        href;
    logic [7:0]  d_in;
    logic        cap_en;
    logic        buf_ready;
    logic [15:0] d_out;
    logic [15:0] w_addr;
    logic        w_en;
    logic        frame_done;
    logic        drop_err;
    logic [7:0]  frame_cnt;

    modport master (
        output vsync, href, d_in, cap_en, buf_ready,
        input  d_out, w_addr, w_en, frame_done, drop_err, frame_cnt
    );

    modport slave (
        input  vsync, href, d_in, cap_en, buf_ready,
        output d_out, w_addr, w_en, frame_done, drop_err, frame_cnt
    );
endinterface

// File: rtl/ov7670_capture.sv
// Pairs OV7670 bytes into RGB565 pixels and writes a cropped window to the frame buffer.
// w_en fires 2 cycles after the low byte; with buf_ready low the pixel is dropped and drop_err latches.
module ov7670_capture #(
    parameter int LINE_W  = 320,
    parameter int CROP_X0 = 32,
    parameter int CROP_Y0 = 0,
    parameter int CROP_W  = 256,
    parameter int CROP_H  = 240
) (
    input  logic            p_clk,
    input  logic            rst_n,
    ov7670_capture_if.slave cam
);

    typedef enum logic [1:0] {IDLE, WAIT_VS_HI, WAIT_VS_LO, ACTIVE} state_t;

    localparam logic [11:0] X_LO  = 12'(CROP_X0);
    localparam logic [11:0] X_W   = 12'(CROP_W);
    localparam logic [11:0] X_MAX = 12'(LINE_W);
    localparam logic [9:0]  Y_LO  = 10'(CROP_Y0);
    localparam logic [9:0]  Y_H   = 10'(CROP_H);

    state_t      r_state;
    logic        r_vs, r_vs_d, r_href, r_href_d;
    logic [7:0]  r_d, r_hi;
    logic        r_phase;
    logic [10:0] r_col;
    logic [8:0]  r_row;
    logic [15:0] r_d_out, r_w_addr;
    logic        r_w_en, r_frame_done, r_drop_err;
    logic [7:0]  r_frame_cnt;

    logic        w_vs_rise, w_vs_fall, w_href_fall, w_in_win;
    logic [11:0] w_col_off;
    logic [9:0]  w_row_off;

    assign w_vs_rise   =  r_vs & ~r_vs_d;
    assign w_vs_fall   = ~r_vs &  r_vs_d;
    assign w_href_fall = ~r_href & r_href_d;

    // Offsets below the origin wrap to large unsigned values and fall outside the window.
    assign w_col_off = {1'b0, r_col} - X_LO;
    assign w_row_off = {1'b0, r_row} - Y_LO;
    assign w_in_win  = (w_col_off < X_W) && ({1'b0, r_col} < X_MAX) && (w_row_off < Y_H);

    always_ff @(posedge p_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_vs         <= 1'b0;
            r_vs_d       <= 1'b0;
            r_href       <= 1'b0;
            r_href_d     <= 1'b0;
            r_d          <= 8'd0;
            r_hi         <= 8'd0;
            r_phase      <= 1'b0;
            r_col        <= 11'd0;
            r_row        <= 9'd0;
            r_d_out      <= 16'd0;
            r_w_addr     <= 16'd0;
            r_w_en       <= 1'b0;
            r_frame_done <= 1'b0;
            r_drop_err   <= 1'b0;
            r_frame_cnt  <= 8'd0;
        end else begin
            r_vs         <= cam.vsync;
            r_vs_d       <= r_vs;
            r_href       <= cam.href;
            r_href_d     <= r_href;
            r_d          <= cam.d_in;
            r_w_en       <= 1'b0;
            r_frame_done <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (cam.cap_en) r_state <= WAIT_VS_HI;
                end
                WAIT_VS_HI: begin
                    if (r_vs) r_state <= WAIT_VS_LO;
                end
                WAIT_VS_LO: begin
                    if (w_vs_fall) begin
                        r_state    <= ACTIVE;
                        r_row      <= 9'd0;
                        r_col      <= 11'd0;
                        r_phase    <= 1'b0;
                        r_drop_err <= 1'b0;
                    end
                end
                ACTIVE: begin
                    // Frame end wins over a coincident line end; counters reset at next frame start.
                    if (w_vs_rise) begin
                        r_frame_done <= 1'b1;
                        r_frame_cnt  <= r_frame_cnt + 8'd1;
                        r_state      <= cam.cap_en ? WAIT_VS_LO : IDLE;
                    end else if (w_href_fall) begin
                        r_row   <= r_row + 9'd1;
                        r_col   <= 11'd0;
                        r_phase <= 1'b0;
                    end else if (r_href) begin
                        r_phase <= ~r_phase;
                        if (!r_phase) begin
                            r_hi <= r_d;
                        end else begin
                            r_col <= r_col + 11'd1;
                            if (w_in_win) begin
                                if (cam.buf_ready) begin
                                    r_w_en   <= 1'b1;
                                    r_d_out  <= {r_hi, r_d};
                                    r_w_addr <= {w_row_off[7:0], w_col_off[7:0]};
                                end else begin
                                    r_drop_err <= 1'b1;
                                end
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cam.d_out      = r_d_out;
    assign cam.w_addr     = r_w_addr;
    assign cam.w_en       = r_w_en;
    assign cam.frame_done = r_frame_done;
    assign cam.drop_err   = r_drop_err;
    assign cam.frame_cnt  = r_frame_cnt;

endmodule
